multicycle_controller: RTL and testbench

Control FSM for the 8-bit multicycle MIPS core. It sits directly beside the datapath: it consumes `op`, `funct` and `zero` from the datapath and drives every datapath control strobe. It sequences a 4-byte instruction fetch, then decode, then the per-instruction execute, memory and writeback steps. It supports LB, SB, R-type (ADD/SUB/AND/OR/SLT), BEQ and J, plus optional ADDI.

---
 rtl/multicycle_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for the 8-bit multicycle MIPS core; CTRL_ADDI_EN adds ADDI (rt <= rs + imm).
// Latency: Moore outputs per state, LB 8 / SB, R-type, ADDI 7 / BEQ, J 6 / illegal 5 cycles.
// Backpressure: none; one step per clock, and reset aborts the instruction and masks writes that cycle.
module multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       iord,
   output logic       memwrite,
   output logic [3:0] irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [2:0] alucont,
   output logic [1:0] pcsource,
   output logic       illegal_op
);

   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
`ifdef CTRL_ADDI_EN
   localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [3:0] {
      FETCH1  = 4'd0,
      FETCH2  = 4'd1,
      FETCH3  = 4'd2,
      FETCH4  = 4'd3,
      DECODE  = 4'd4,
      MEMADR  = 4'd5,
      LBRD    = 4'd6,
      LBWR    = 4'd7,
      SBWR    = 4'd8,
      RTYPEEX = 4'd9,
      RTYPEWR = 4'd10,
      BEQEX   = 4'd11,
      JEX     = 4'd12
`ifdef CTRL_ADDI_EN
      ,
      ADDIEX  = 4'd13,
      ADDIWR  = 4'd14
`endif
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic       pcwrite;
   logic       branch;
   logic [2:0] funct_alu;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH1;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      funct_alu = ALU_ADD;
      case (funct)
         6'b100000: funct_alu = ALU_ADD;
         6'b100010: funct_alu = ALU_SUB;
         6'b100100: funct_alu = ALU_AND;
         6'b100101: funct_alu = ALU_OR;
         6'b101010: funct_alu = ALU_SLT;
         default:   funct_alu = ALU_ADD;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 4'b0000;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      alucont    = ALU_ADD;
      pcsource   = 2'b00;
      illegal_op = 1'b0;

      case (state_q)
         FETCH1: begin
            irwrite = 4'b0001;
            alusrcb = 2'b01;
            pcwrite = 1'b1;
            state_d = FETCH2;
         end
         FETCH2: begin
            irwrite = 4'b0010;
            alusrcb = 2'b01;
            pcwrite = 1'b1;
            state_d = FETCH3;
         end
         FETCH3: begin
            irwrite = 4'b0100;
            alusrcb = 2'b01;
            pcwrite = 1'b1;
            state_d = FETCH4;
         end
         FETCH4: begin
            irwrite = 4'b1000;
            alusrcb = 2'b01;
            pcwrite = 1'b1;
            state_d = DECODE;
         end
         DECODE: begin
            // Speculative branch target computed here so BEQEX can use ALUOUT.
            alusrcb = 2'b11;
            case (op)
               OP_LB, OP_SB: state_d = MEMADR;
               OP_RTYPE:     state_d = RTYPEEX;
               OP_BEQ:       state_d = BEQEX;
               OP_J:         state_d = JEX;
`ifdef CTRL_ADDI_EN
               OP_ADDI:      state_d = ADDIEX;
`endif
               default: begin
                  illegal_op = 1'b1;
                  state_d    = FETCH1;
               end
            endcase
         end
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = (op == OP_LB) ? LBRD : SBWR;
         end
         LBRD: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            iord    = 1'b1;
            state_d = LBWR;
         end
         LBWR: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
            state_d  = FETCH1;
         end
         SBWR: begin
            alusrca  = 1'b1;
            alusrcb  = 2'b10;
            iord     = 1'b1;
            memwrite = 1'b1;
            state_d  = FETCH1;
         end
         RTYPEEX: begin
            alusrca = 1'b1;
            alucont = funct_alu;
            state_d = RTYPEWR;
         end
         RTYPEWR: begin
            // ALU kept live: write data comes straight from the ALU result.
            alusrca  = 1'b1;
            alucont  = funct_alu;
            regdst   = 1'b1;
            regwrite = 1'b1;
            state_d  = FETCH1;
         end
         BEQEX: begin
            alusrca  = 1'b1;
            alucont  = ALU_SUB;
            pcsource = 2'b01;
            branch   = 1'b1;
            state_d  = FETCH1;
         end
         JEX: begin
            pcsource = 2'b10;
            pcwrite  = 1'b1;
            state_d  = FETCH1;
         end
`ifdef CTRL_ADDI_EN
         ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = ADDIWR;
         end
         ADDIWR: begin
            alusrca  = 1'b1;
            alusrcb  = 2'b10;
            regwrite = 1'b1;
            state_d  = FETCH1;
         end
`endif
         default: state_d = FETCH1;
      endcase

      pcen = pcwrite | (branch & zero);

      if (reset) begin
         state_d    = FETCH1;
         pcen       = 1'b0;
         iord       = 1'b0;
         memwrite   = 1'b0;
         irwrite    = 4'b0000;
         regdst     = 1'b0;
         memtoreg   = 1'b0;
         regwrite   = 1'b0;
         alusrca    = 1'b0;
         alusrcb    = 2'b00;
         alucont    = ALU_ADD;
         pcsource   = 2'b00;
         illegal_op = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboarded bench for multicycle_controller: expected control words are queued per cycle
// by the stimulus and popped/compared on each falling edge by an independent monitor.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       pcen, iord, memwrite, regdst, memtoreg, regwrite, alusrca, illegal_op;
   logic [3:0] irwrite;
   logic [1:0] alusrcb, pcsource;
   logic [2:0] alucont;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
      .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
      .alusrca(alusrca), .alusrcb(alusrcb), .alucont(alucont),
      .pcsource(pcsource), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pcen;
      logic       iord;
      logic       memwrite;
      logic [3:0] irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [2:0] alucont;
      logic [1:0] pcsource;
      logic       illegal_op;
   } ctl_t;

   ctl_t  exp_q[$];
   string tag_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   ctl_t  mon_got;
   ctl_t  mon_exp;
   string mon_tag;

   // ---------------- expected control words, one per FSM state ----------------
   function automatic ctl_t w_dflt();
      ctl_t c;
      c = '0;
      c.alucont = 3'b010;
      return c;
   endfunction

   function automatic ctl_t w_fetch(input int n);
      ctl_t c;
      c = w_dflt();
      c.irwrite = 4'b0001 << n;
      c.alusrcb = 2'b01;
      c.pcen    = 1'b1;
      return c;
   endfunction

   function automatic ctl_t w_decode(input logic ill);
      ctl_t c;
      c = w_dflt();
      c.alusrcb    = 2'b11;
      c.illegal_op = ill;
      return c;
   endfunction

   function automatic ctl_t w_memadr();
      ctl_t c;
      c = w_dflt();
      c.alusrca = 1'b1;
      c.alusrcb = 2'b10;
      return c;
   endfunction

   function automatic ctl_t w_rtype(input logic [2:0] ac, input logic wr);
      ctl_t c;
      c = w_dflt();
      c.alusrca  = 1'b1;
      c.alucont  = ac;
      c.regdst   = wr;
      c.regwrite = wr;
      return c;
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_got = '{pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                     alusrca, alusrcb, alucont, pcsource, illegal_op};
         mon_exp = exp_q.pop_front();
         mon_tag = tag_q.pop_front();
         n_checks++;
         if (mon_got !== mon_exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (t=%0t)", mon_tag, mon_got, mon_exp, $time);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push(input ctl_t c, input string t);
      exp_q.push_back(c);
      tag_q.push_back(t);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic z,
                        input logic ill, input string name);
      op    = o;
      funct = f;
      zero  = z;
      for (int i = 0; i < 4; i++) push(w_fetch(i), $sformatf("%s_fetch%0d", name, i + 1));
      push(w_decode(ill), {name, "_decode"});
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      ctl_t c;
      reset = 1'b1;
      op    = 6'b0;
      funct = 6'b0;
      zero  = 1'b0;
      for (int i = 0; i < 3; i++) push(w_dflt(), $sformatf("reset_cyc%0d", i));
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b0;

      // LB: 8 cycles
      issue(6'b100000, 6'b0, 1'b0, 1'b0, "lb");
      push(w_memadr(), "lb_memadr");
      c = w_memadr(); c.iord = 1'b1; push(c, "lb_lbrd");
      c = w_dflt(); c.memtoreg = 1'b1; c.regwrite = 1'b1; push(c, "lb_lbwr");
      wait_cyc(8);

      // SB: 7 cycles
      issue(6'b101000, 6'b0, 1'b0, 1'b0, "sb");
      push(w_memadr(), "sb_memadr");
      c = w_memadr(); c.iord = 1'b1; c.memwrite = 1'b1; push(c, "sb_sbwr");
      wait_cyc(7);

      // R-type across every funct mapping plus an unknown funct
      begin
         logic [5:0] fv [6];
         logic [2:0] av [6];
         fv = '{6'b100010, 6'b101010, 6'b100000, 6'b100100, 6'b100101, 6'b111111};
         av = '{3'b110,    3'b111,    3'b010,    3'b000,    3'b001,    3'b010};
         for (int k = 0; k < 6; k++) begin
            issue(6'b000000, fv[k], 1'b0, 1'b0, $sformatf("rtype_f%b", fv[k]));
            push(w_rtype(av[k], 1'b0), $sformatf("rtype_f%b_ex", fv[k]));
            push(w_rtype(av[k], 1'b1), $sformatf("rtype_f%b_wr", fv[k]));
            wait_cyc(7);
         end
      end

      // BEQ taken / not taken: 6 cycles each
      for (int z = 1; z >= 0; z--) begin
         issue(6'b000100, 6'b0, z[0], 1'b0, $sformatf("beq_z%0d", z));
         c = w_dflt(); c.alusrca = 1'b1; c.alucont = 3'b110; c.pcsource = 2'b01;
         c.pcen = z[0];
         push(c, $sformatf("beq_z%0d_beqex", z));
         wait_cyc(6);
      end

      // J: 6 cycles
      issue(6'b000010, 6'b0, 1'b0, 1'b0, "j");
      c = w_dflt(); c.pcsource = 2'b10; c.pcen = 1'b1; push(c, "j_jex");
      wait_cyc(6);

      // Illegal op: 5 cycles
      issue(6'b111111, 6'b0, 1'b0, 1'b1, "ill");
      wait_cyc(5);

      // ADDI: either a 7-cycle add-immediate or an illegal opcode
`ifdef CTRL_ADDI_EN
      issue(6'b001000, 6'b0, 1'b0, 1'b0, "addi");
      push(w_memadr(), "addi_ex");
      c = w_memadr(); c.regwrite = 1'b1; push(c, "addi_wr");
      wait_cyc(7);
`else
      issue(6'b001000, 6'b0, 1'b0, 1'b1, "addi_off");
      wait_cyc(5);
`endif

      // Reset landing on SBWR must suppress the memory write and restart fetch
      issue(6'b101000, 6'b0, 1'b0, 1'b0, "sbabort");
      push(w_memadr(), "sbabort_memadr");
      push(w_dflt(), "sbabort_reset_cycle");
      wait_cyc(6);
      reset = 1'b1;
      wait_cyc(1);
      reset = 1'b0;

      // Following instruction fetches cleanly after the abort
      issue(6'b000010, 6'b0, 1'b0, 1'b0, "j_after_abort");
      c = w_dflt(); c.pcsource = 2'b10; c.pcen = 1'b1; push(c, "j_after_abort_jex");
      wait_cyc(6);

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
